// File: rtl/cpu_bus_responder_pkg.sv
// Shared definitions for the CPU bus responder.
// Holds the two-state FSM encoding, the hard-wired vector addresses at the
// top of the address map, and the data byte returned when an access times out.
package cpu_bus_responder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } busState_t;

  localparam logic [15:0] VEC_NMI_LO   = 16'hFFFA;
  localparam logic [15:0] VEC_NMI_HI   = 16'hFFFB;
  localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
  localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;
  localparam logic [15:0] VEC_IRQ_LO   = 16'hFFFE;
  localparam logic [15:0] VEC_IRQ_HI   = 16'hFFFF;

  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

  // The vector window runs to the top of the 16-bit map, so a lower bound suffices.
  function automatic logic isVectorAddr(input logic [15:0] addr);
    return (addr >= VEC_NMI_LO);
  endfunction

endpackage

// File: rtl/cpu_bus_responder_vector_rom.sv
// vector_rom: combinational lookup of the vector byte for a read in the
// 0xFFFA..0xFFFF window.
// Ports:
//   addrBits    in  3   CPU address bits 2:0
//   resetVector in  16  reset vector (0xFFFC/0xFFFD)
//   nmiVector   in  16  NMI vector   (0xFFFA/0xFFFB)
//   irqVector   in  16  IRQ vector   (0xFFFE/0xFFFF)
//   vectorByte  out 8   selected byte (even address = low byte)
module vector_rom
  import cpu_bus_responder_pkg::*;
(
  input  logic [2:0]  addrBits,
  input  logic [15:0] resetVector,
  input  logic [15:0] nmiVector,
  input  logic [15:0] irqVector,
  output logic [7:0]  vectorByte
);

  // Byte select on the low three address bits; unused codes read as zero.
  always_comb begin
    vectorByte = 8'h00;
    case (addrBits)
      VEC_NMI_LO[2:0]:   vectorByte = nmiVector[7:0];
      VEC_NMI_HI[2:0]:   vectorByte = nmiVector[15:8];
      VEC_RESET_LO[2:0]: vectorByte = resetVector[7:0];
      VEC_RESET_HI[2:0]: vectorByte = resetVector[15:8];
      VEC_IRQ_LO[2:0]:   vectorByte = irqVector[7:0];
      VEC_IRQ_HI[2:0]:   vectorByte = irqVector[15:8];
      default:           vectorByte = 8'h00;
    endcase
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: answers CPU vector fetches locally and forwards all other
// accesses to an external memory with a single-cycle ack, timing out after
// TIMEOUT_CYCLES wait cycles with a sticky bus error.
// Ports:
//   clk, rst                       clock, async active-high reset
//   cpuAddressLow/High [7:0]       CPU address
//   cpuDataWrite [7:0]             CPU write data
//   cpuReadWrite                   1=read, 0=write
//   cpuAccessValid                 access request
//   cpuDataRead [7:0]              registered read data
//   cpuReady                       high while IDLE
//   memRequest                     high while WAIT
//   memWriteEnable                 latched write flag
//   memAddress [15:0]              latched address
//   memWriteData [7:0]             latched write data
//   memReadData [7:0], memAck      memory response
//   busError, busErrorClear        sticky timeout flag and its clear
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR   = 16'hF000,
  parameter logic [15:0] NMI_VECTOR     = 16'hF100,
  parameter logic [15:0] IRQ_VECTOR     = 16'hF200,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cpuAddressLow,
  input  logic [7:0]  cpuAddressHigh,
  input  logic [7:0]  cpuDataWrite,
  input  logic        cpuReadWrite,
  input  logic        cpuAccessValid,
  output logic [7:0]  cpuDataRead,
  output logic        cpuReady,
  output logic        memRequest,
  output logic        memWriteEnable,
  output logic [15:0] memAddress,
  output logic [7:0]  memWriteData,
  input  logic [7:0]  memReadData,
  input  logic        memAck,
  output logic        busError,
  input  logic        busErrorClear
);

  // Last counter value before the timeout fires.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  busState_t   state_r;
  logic [7:0]  waitCount_r;
  logic [7:0]  cpuDataRead_r;
  logic [15:0] memAddress_r;
  logic [7:0]  memWriteData_r;
  logic        memWriteEnable_r;
  logic        busError_r;

  logic [15:0] cpuAddress_s;
  logic [7:0]  vectorByte_s;
  logic        timeoutHit_s;

  assign cpuAddress_s = {cpuAddressHigh, cpuAddressLow};

  // Ack has priority: the timeout only fires on a WAIT cycle without memAck.
  assign timeoutHit_s = (state_r == ST_WAIT) && !memAck && (waitCount_r == TIMEOUT_LAST);

  vector_rom uVectorRom (
    .addrBits    (cpuAddress_s[2:0]),
    .resetVector (RESET_VECTOR),
    .nmiVector   (NMI_VECTOR),
    .irqVector   (IRQ_VECTOR),
    .vectorByte  (vectorByte_s)
  );

  // Access FSM: vector reads are served from IDLE, everything else goes through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      waitCount_r      <= 8'h00;
      cpuDataRead_r    <= 8'h00;
      memAddress_r     <= 16'h0000;
      memWriteData_r   <= 8'h00;
      memWriteEnable_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpuAccessValid) begin
            if (cpuReadWrite && isVectorAddr(cpuAddress_s)) begin
              cpuDataRead_r <= vectorByte_s;
            end else begin
              memAddress_r     <= cpuAddress_s;
              memWriteData_r   <= cpuDataWrite;
              memWriteEnable_r <= ~cpuReadWrite;
              waitCount_r      <= 8'h00;
              state_r          <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (memAck) begin
            state_r <= ST_IDLE;
            if (!memWriteEnable_r) begin
              cpuDataRead_r <= memReadData;
            end
          end else if (timeoutHit_s) begin
            state_r <= ST_IDLE;
            if (!memWriteEnable_r) begin
              cpuDataRead_r <= TIMEOUT_DATA;
            end
          end else begin
            waitCount_r <= waitCount_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky bus error: a timeout in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busError_r <= 1'b0;
    end else if (timeoutHit_s) begin
      busError_r <= 1'b1;
    end else if (busErrorClear) begin
      busError_r <= 1'b0;
    end else begin
      busError_r <= busError_r;
    end
  end

  assign cpuReady       = (state_r == ST_IDLE);
  assign memRequest     = (state_r == ST_WAIT);
  assign cpuDataRead    = cpuDataRead_r;
  assign memAddress     = memAddress_r;
  assign memWriteData   = memWriteData_r;
  assign memWriteEnable = memWriteEnable_r;
  assign busError       = busError_r;

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 Parameter RESET_VECTOR, default 16'hF000: value returned on reads of 0xFFFC (low byte) and 0xFFFD (high byte).
REQ-002 Parameter NMI_VECTOR, default 16'hF100: value returned on reads of 0xFFFA/0xFFFB.
REQ-003 Parameter IRQ_VECTOR, default 16'hF200: value returned on reads of 0xFFFE/0xFFFF.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, legal range 1..255: wait-cycle limit before a bus error.
REQ-005 Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpuAddressLow  in  8  CPU address bits 7:0.
- cpuAddressHigh  in  8  CPU address bits 15:8.
- cpuDataWrite  in  8  CPU write data.
- cpuReadWrite  in  1  1=read, 0=write.
- cpuAccessValid  in  1  access request this cycle.
- cpuDataRead  out  8  read data to CPU.
- cpuReady  out  1  1=responder can accept; 0=CPU must stall.
- memRequest  out  1  memory access in progress.
- memWriteEnable  out  1  1=write access.
- memAddress  out  16  latched access address.
- memWriteData  out  8  latched write data.
- memReadData  in  8  memory read data, valid with memAck.
- memAck  in  1  single-cycle completion strobe.
- busError  out  1  sticky timeout flag.
- busErrorClear  in  1  clears busError.

Function
REQ-006 FSM states are IDLE and WAIT only.
REQ-007 cpuReady is 1 exactly when the state is IDLE; memRequest is 1 exactly when the state is WAIT.
REQ-008 IDLE, cpuAccessValid=1, read, address 0xFFFA..0xFFFF: cpuDataRead loads the vector byte at the next edge, and the FSM stays in IDLE with no memory access.
REQ-009 IDLE, cpuAccessValid=1, any other access (including writes to 0xFFFA..0xFFFF): at the next edge, latch memAddress={high,low}, memWriteData, memWriteEnable=~cpuReadWrite, clear the wait counter, and enter WAIT.
REQ-010 memAddress, memWriteData and memWriteEnable hold steady throughout WAIT.
REQ-011 WAIT, memAck=1: return to IDLE at the next edge; on a read, cpuDataRead loads memReadData; on a write, cpuDataRead is unchanged.
REQ-012 WAIT, memAck=0: the 8-bit wait counter increments each cycle.
REQ-013 When the counter equals TIMEOUT_CYCLES-1 with memAck=0: next edge returns to IDLE, sets busError, and on a read loads cpuDataRead=8'hFF.
REQ-014 If memAck and the timeout condition occur in the same cycle, memAck wins and busError is not set.
REQ-015 memAck while in IDLE is ignored.
REQ-016 cpuAccessValid while in WAIT is ignored and is not queued.
REQ-017 busErrorClear=1 clears busError at the next edge; a simultaneous set takes priority over clear.
REQ-018 Minimum external access latency is 2 cycles: accept edge, then ack edge.

Reset
REQ-019 rst=1 immediately forces the state to IDLE, the counter to 0, cpuDataRead=8'h00, memAddress=16'h0000, memWriteData=8'h00, memWriteEnable=0 and busError=0.
REQ-020 Reset asserted mid-WAIT aborts the access, drops memRequest immediately, and any later memAck is ignored.

Structure
REQ-021 A shared package holds the FSM state typedef, the vector addresses 0xFFFA..0xFFFF, and the timeout-data constant 8'hFF.
REQ-022 One combinational sub-module, vector_rom, maps address bits 2:0 plus the three vector parameters to the vector byte.
REQ-023 All outputs are registered or decoded directly from the state; there is no combinational path from memAck to cpuReady.

Verification
REQ-024 Reset: read 0xFFFC, then 0xFFFD -> cpuDataRead 8'h00 then 8'hF0, cpuReady stays 1, memRequest never asserts.
REQ-025 Read 0x1234, memAck 3 cycles later with memReadData=8'h5A -> memAddress=16'h1234, cpuReady low 3 cycles, cpuDataRead=8'h5A.
REQ-026 Write 8'hC3 to 0xFFFE, ack after 1 cycle -> memWriteEnable=1, memWriteData=8'hC3, cpuDataRead unchanged.
REQ-027 Read with no ack, TIMEOUT_CYCLES=16 -> return to IDLE after 16 WAIT cycles, cpuDataRead=8'hFF, busError=1; same-cycle busErrorClear leaves it 1; a later clear gives 0.
REQ-028 memAck on the timeout cycle -> acked data returned, busError stays 0.
REQ-029 rst pulsed mid-WAIT, then memAck -> state IDLE, all outputs at reset values, ack ignored.
